// File: rtl/lut_prog_pkg.sv
// ============================================================================
// Module      : lut_prog_pkg
// Description : Shared defaults and types for the branch-target LUT loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_prog_pkg;

    localparam int C_ENTRIES_DEFAULT = 256;
    localparam int C_PC_W_DEFAULT    = 12;

    // Load-stream record parser states.
    typedef enum logic [1:0] {
        S_LABEL  = 2'd0,
        S_PC_HI  = 2'd1,
        S_PC_LO  = 2'd2,
        S_COMMIT = 2'd3
    } rx_state_t;

    typedef logic [C_PC_W_DEFAULT-1:0] pc_t;

endpackage

`default_nettype wire

// File: rtl/lut_prog_rx.sv
// ============================================================================
// Module      : lut_prog_rx
// Description : Byte parser for 3-byte {label, pc_hi, pc_lo} load records.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_prog_rx
    import lut_prog_pkg::*;
#(
    parameter int PC_W = C_PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_clear,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            busy,
    output logic [7:0]      rec_label,
    output logic [PC_W-1:0] rec_pc,
    output logic            commit,
    output logic            bad
);

    rx_state_t  r_state;
    rx_state_t  w_state_next;
    logic [7:0] r_label;
    logic [7:0] r_pc_hi;
    logic [7:0] r_pc_lo;
    logic       w_xfer;
    logic       w_hi_ok;
    logic       w_commit_slot;
    pc_t        w_rec_pc;

    assign in_ready      = (r_state != S_COMMIT) && !reset;
    assign busy          = (r_state != S_LABEL);
    assign w_xfer        = in_valid && in_ready;
    assign w_hi_ok       = (r_pc_hi[7:4] == 4'h0);
    // Clear requests cancel a commit that is in flight.
    assign w_commit_slot = (r_state == S_COMMIT) && !reset && !load_clear;
    assign commit        = w_commit_slot && w_hi_ok;
    assign bad           = w_commit_slot && !w_hi_ok;
    assign rec_label     = r_label;
    assign w_rec_pc      = {r_pc_hi[3:0], r_pc_lo};

    always_ff @(posedge clk) begin
        if (reset || load_clear) begin
            r_state <= S_LABEL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_label <= 8'h00;
            r_pc_hi <= 8'h00;
            r_pc_lo <= 8'h00;
        end else if (w_xfer) begin
            case (r_state)
                S_LABEL: r_label <= in_data;
                S_PC_HI: r_pc_hi <= in_data;
                S_PC_LO: r_pc_lo <= in_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LABEL:  if (w_xfer) w_state_next = S_PC_HI;
            S_PC_HI:  if (w_xfer) w_state_next = S_PC_LO;
            S_PC_LO:  if (w_xfer) w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_LABEL;
            default:  w_state_next = S_LABEL;
        endcase
    end

    generate
        if (PC_W == $bits(pc_t)) begin : g_pc_exact
            assign rec_pc = w_rec_pc;
        end else if (PC_W > $bits(pc_t)) begin : g_pc_wide
            assign rec_pc = {{(PC_W-$bits(pc_t)){1'b0}}, w_rec_pc};
        end else begin : g_pc_narrow
            assign rec_pc = w_rec_pc[PC_W-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/lut_prog.sv
// ============================================================================
// Module      : lut_prog
// Description : Stream-loaded label -> branch-target table with async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_prog
    import lut_prog_pkg::*;
#(
    parameter int ENTRIES = C_ENTRIES_DEFAULT,
    parameter int PC_W    = C_PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_clear,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic [7:0]      label,
    output logic [PC_W-1:0] next_pc,
    output logic            busy,
    output logic [8:0]      entry_count,
    output logic            err
);

    logic [PC_W-1:0]    r_table [ENTRIES];
    logic [ENTRIES-1:0] r_written;
    logic [8:0]         r_count;
    logic               r_err;

    logic               w_commit;
    logic               w_bad;
    logic [7:0]         w_rec_label;
    logic [PC_W-1:0]    w_rec_pc;
    logic               w_slot_ok;
    logic               w_read_ok;

    lut_prog_rx #(
        .PC_W       (PC_W)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .load_clear (load_clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .rec_label  (w_rec_label),
        .rec_pc     (w_rec_pc),
        .commit     (w_commit),
        .bad        (w_bad)
    );

    // Labels beyond a reduced table size are dropped on write and read as 0.
    assign w_slot_ok = (int'(w_rec_label) < ENTRIES);
    assign w_read_ok = (int'(label) < ENTRIES);

    always_ff @(posedge clk) begin
        if (reset || load_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
            r_written <= '0;
            r_count   <= 9'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_commit && w_slot_ok) begin
                r_table[w_rec_label]   <= w_rec_pc;
                r_written[w_rec_label] <= 1'b1;
                if (!r_written[w_rec_label]) begin
                    r_count <= r_count + 9'd1;
                end
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign next_pc     = w_read_ok ? r_table[label] : '0;
    assign entry_count = r_count;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lut_prog.sv
// ============================================================================
// Module      : tb_lut_prog
// Description : Directed and table-driven self-checking bench for lut_prog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_clear;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  label;
    logic [11:0] next_pc;
    logic        busy;
    logic [8:0]  entry_count;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0]  lbl;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] pc;
        logic [8:0]  cnt;
        logic        e;
    } vec_t;

    vec_t        vecs [7];
    logic [11:0] model [256];

    lut_prog dut (
        .clk         (clk),
        .reset       (reset),
        .load_clear  (load_clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .label       (label),
        .next_pc     (next_pc),
        .busy        (busy),
        .entry_count (entry_count),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 8) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        step();
    endtask

    task automatic send_rec(input logic [7:0] l, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(l);
        send_byte(hi);
        send_byte(lo);
        in_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] l, input logic [11:0] exp);
        label = l;
        #1;
        chk(name, 32'(next_pc), 32'(exp));
    endtask

    initial begin
        int bad;
        int c0;
        logic [11:0] pc;

        vecs[0] = '{8'h10, 8'h01, 8'h23, 12'h123, 9'd1, 1'b0};
        vecs[1] = '{8'hFF, 8'h0F, 8'hFF, 12'hFFF, 9'd2, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 12'h000, 9'd3, 1'b0};
        vecs[3] = '{8'h10, 8'h04, 8'h56, 12'h456, 9'd3, 1'b0};
        vecs[4] = '{8'h20, 8'h80, 8'h11, 12'h000, 9'd3, 1'b1};
        vecs[5] = '{8'h20, 8'h0A, 8'hBC, 12'hABC, 9'd4, 1'b1};
        vecs[6] = '{8'h00, 8'h0F, 8'h00, 12'hF00, 9'd4, 1'b1};

        reset = 1'b1; load_clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; label = 8'h00;
        step();
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(entry_count), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            label = 8'(i);
            #1;
            if (next_pc !== 12'h000) bad++;
        end
        chk("reset_table_zero", 32'(bad), 32'd0);
        step();

        // First record: one-cycle commit bubble, old value visible during it.
        label = 8'h02;
        send_rec(8'h02, 8'h01, 8'h45);
        chk("commit_ready_low", 32'(in_ready), 32'd0);
        chk("commit_busy", 32'(busy), 32'd1);
        read_chk("commit_old_l2", 8'h02, 12'h000);
        step();
        chk("post_commit_ready", 32'(in_ready), 32'd1);
        chk("post_commit_busy", 32'(busy), 32'd0);
        read_chk("l2_value", 8'h02, 12'h145);
        chk("count_1", 32'(entry_count), 32'd1);

        // Back-to-back rewrite of label 7 with in_valid held: 4 cycles/record.
        label = 8'h07;
        c0 = cyc;
        send_byte(8'h07); send_byte(8'h00); send_byte(8'hF7);
        send_byte(8'h07); send_byte(8'h00); send_byte(8'hAB);
        in_valid = 1'b0;
        chk("rate_cycles", 32'(cyc - c0), 32'd7);
        read_chk("rewrite_old_l7", 8'h07, 12'h0F7);
        step();
        read_chk("rewrite_new_l7", 8'h07, 12'h0AB);
        chk("rewrite_count", 32'(entry_count), 32'd2);

        // Malformed record sets err, writes nothing; parser recovers.
        send_rec(8'h05, 8'h31, 8'h00);
        step();
        chk("bad_err", 32'(err), 32'd1);
        read_chk("bad_no_write", 8'h05, 12'h000);
        chk("bad_count", 32'(entry_count), 32'd2);
        send_rec(8'h05, 8'h0A, 8'hBC);
        step();
        read_chk("recover_l5", 8'h05, 12'hABC);
        chk("recover_count", 32'(entry_count), 32'd3);
        chk("err_sticky", 32'(err), 32'd1);

        // Partial record dropped by load_clear.
        send_byte(8'h09); send_byte(8'h01);
        in_valid = 1'b0;
        chk("partial_busy", 32'(busy), 32'd1);
        load_clear = 1'b1;
        step();
        load_clear = 1'b0;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_ready", 32'(in_ready), 32'd1);
        chk("clear_count", 32'(entry_count), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        read_chk("clear_l2", 8'h02, 12'h000);
        send_rec(8'h0C, 8'h03, 8'h21);
        step();
        read_chk("fresh_l0c", 8'h0C, 12'h321);
        read_chk("stale_l09", 8'h09, 12'h000);
        chk("fresh_count", 32'(entry_count), 32'd1);

        load_clear = 1'b1;
        step();
        load_clear = 1'b0;
        for (int v = 0; v < 7; v++) begin
            send_rec(vecs[v].lbl, vecs[v].hi, vecs[v].lo);
            step();
            read_chk($sformatf("vec%0d_pc", v), vecs[v].lbl, vecs[v].pc);
            chk($sformatf("vec%0d_count", v), 32'(entry_count), 32'(vecs[v].cnt));
            chk($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].e));
        end

        // load_clear during S_COMMIT wins over the write.
        send_rec(8'h33, 8'h01, 8'h11);
        load_clear = 1'b1;
        step();
        load_clear = 1'b0;
        read_chk("clear_vs_commit", 8'h33, 12'h000);
        chk("clear_vs_commit_cnt", 32'(entry_count), 32'd0);

        // Reset mid-record drops it.
        send_rec(8'h44, 8'h02, 8'h22);
        step();
        chk("pre_reset_count", 32'(entry_count), 32'd1);
        send_byte(8'h55); send_byte(8'h01);
        reset = 1'b1;
        #1;
        chk("reset_mid_ready", 32'(in_ready), 32'd0);
        step();
        reset = 1'b0;
        send_byte(8'h66);
        in_valid = 1'b0;
        step(); step();
        read_chk("reset_mid_l55", 8'h55, 12'h000);
        read_chk("reset_mid_l44", 8'h44, 12'h000);
        read_chk("reset_mid_l66", 8'h66, 12'h000);
        chk("reset_mid_count", 32'(entry_count), 32'd0);
        chk("reset_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // All 256 labels with random stalls between bytes.
        for (int i = 0; i < 256; i++) begin
            pc = 12'((i * 37 + 5) & 12'hFFF);
            model[i] = pc;
            for (int b = 0; b < 3; b++) begin
                int stall;
                stall = $urandom_range(0, 3);
                in_valid = 1'b0;
                repeat (stall) step();
                case (b)
                    0:       send_byte(8'(i));
                    1:       send_byte({4'h0, pc[11:8]});
                    default: send_byte(pc[7:0]);
                endcase
            end
        end
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 256; i++) begin
            read_chk($sformatf("full_l%0d", i), 8'(i), model[i]);
        end
        chk("full_count", 32'(entry_count), 32'd256);
        chk("full_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
